// File: rtl/keccak_pkg.sv
// Shared definitions for the streaming Keccak theta step.
// Holds the page geometry, the cell index and column-parity helpers,
// and the state encoding of the page sequencer.
package keccak_pkg;

   localparam int unsigned PAGE_W = 25;

   // Page sequencer states
   typedef enum logic [1:0] {
      FIRST,
      STREAM,
      FLUSH,
      DRAIN
   } state_e;

   // Bit position of cell (x,y) inside a page
   function automatic logic [4:0] idx(input int x, input int y);
      return 5'(x + 5 * y);
   endfunction

   // Column parity C[x] = XOR over y of cell (x,y)
   function automatic logic [4:0] col_par(input logic [PAGE_W-1:0] page);
      logic [4:0] par;
      par = '0;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            par[3'(x)] = par[3'(x)] ^ page[idx(x, y)];
         end
      end
      return par;
   endfunction

endpackage

// File: rtl/theta_page_xform.sv
// Combinational theta update of one page.
// Cell (x,y) is XORed with c_cur[(x+4)%5] (same slice) and
// c_prev[(x+1)%5] (slice z-1).
// Ports:
//   page_i   in   25   input page, cell (x,y) at bit x+5*y
//   c_cur_i  in   5    column parity of this page
//   c_prev_i in   5    column parity of the previous page
//   page_o   out  25   transformed page
module theta_page_xform
   import keccak_pkg::*;
(
   input  logic [PAGE_W-1:0] page_i,
   input  logic [4:0]        c_cur_i,
   input  logic [4:0]        c_prev_i,
   output logic [PAGE_W-1:0] page_o
);

   always_comb begin
      page_o = page_i;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            page_o[idx(x, y)] = page_i[idx(x, y)]
                              ^ c_cur_i[3'((x + 4) % 5)]
                              ^ c_prev_i[3'((x + 1) % 5)];
         end
      end
   end

endmodule

// File: rtl/keccak_theta_stream.sv
// Streaming Keccak theta step, one 5x5 slice (page) per beat, z = 0..LANE_W-1.
// Page 0 needs the parity of page LANE_W-1, so it is held and emitted last:
// output order is 1..LANE_W-1, then 0.
// Optional feature macro: KECCAK_THETA_PARITY_OUT_EN adds out_parity_o,
// the column parity of the input page matching out_idx_o.
// Ports:
//   clk            in   1      rising-edge clock
//   rst_n          in   1      asynchronous active-low reset
//   in_valid_i     in   1      in_page_i is valid
//   in_ready_o     out  1      page accepted this cycle
//   in_page_i      in   25     slice, cell (x,y) at bit x+5*y
//   out_valid_o    out  1      out_page_o/out_idx_o valid
//   out_ready_i    in   1      downstream accepts
//   out_page_o     out  25     theta-transformed slice
//   out_idx_o      out  CNT_W  z index of out_page_o
//   out_parity_o   out  5      column parity of the output's source page (macro only)
module keccak_theta_stream
   import keccak_pkg::*;
#(
   parameter  int unsigned LANE_W = 64,
   localparam int unsigned CNT_W  = ($clog2(LANE_W) > 0) ? $clog2(LANE_W) : 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [PAGE_W-1:0] in_page_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [PAGE_W-1:0] out_page_o,
   output logic [CNT_W-1:0]  out_idx_o
`ifdef KECCAK_THETA_PARITY_OUT_EN
   ,
   output logic [4:0]        out_parity_o
`endif
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANE_W - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PAGE_W-1:0]   p0_page_q, p0_page_d;
   logic [4:0]          p0_par_q, p0_par_d;
   logic [4:0]          prev_par_q, prev_par_d;
   logic                out_valid_q, out_valid_d;
   logic [PAGE_W-1:0]   out_page_q, out_page_d;
   logic [CNT_W-1:0]    out_idx_q, out_idx_d;
`ifdef KECCAK_THETA_PARITY_OUT_EN
   logic [4:0]          out_par_q, out_par_d;
`endif

   logic                in_ready_c;
   logic [4:0]          c_in;
   logic                sel_p0;
   logic [PAGE_W-1:0]   xf_page_in;
   logic [4:0]          xf_cur;
   logic [PAGE_W-1:0]   xf_page_out;

   assign c_in = col_par(in_page_i);

   // One transform shared by the streaming result and the deferred page 0
   assign sel_p0     = (state_q == FLUSH);
   assign xf_page_in = sel_p0 ? p0_page_q : in_page_i;
   assign xf_cur     = sel_p0 ? p0_par_q  : c_in;

   theta_page_xform u_xform (
      .page_i   (xf_page_in),
      .c_cur_i  (xf_cur),
      .c_prev_i (prev_par_q),
      .page_o   (xf_page_out)
   );

   // Sequencer next state and datapath loads
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      p0_page_d   = p0_page_q;
      p0_par_d    = p0_par_q;
      prev_par_d  = prev_par_q;
      out_valid_d = out_valid_q;
      out_page_d  = out_page_q;
      out_idx_d   = out_idx_q;
`ifdef KECCAK_THETA_PARITY_OUT_EN
      out_par_d   = out_par_q;
`endif
      in_ready_c  = 1'b0;

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         FIRST: begin
            in_ready_c = 1'b1;
            if (in_valid_i) begin
               p0_page_d  = in_page_i;
               p0_par_d   = c_in;
               prev_par_d = c_in;
               if (LANE_W == 1) begin
                  state_d = FLUSH;
                  cnt_d   = '0;
               end else begin
                  state_d = STREAM;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         STREAM: begin
            // A result leaving this cycle frees the register for the next one
            in_ready_c = !out_valid_q || out_ready_i;
            if (in_valid_i && in_ready_c) begin
               out_valid_d = 1'b1;
               out_page_d  = xf_page_out;
               out_idx_d   = cnt_q;
`ifdef KECCAK_THETA_PARITY_OUT_EN
               out_par_d   = c_in;
`endif
               prev_par_d  = c_in;
               if (cnt_q == LAST_IDX) begin
                  state_d = FLUSH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FLUSH: begin
            if (!out_valid_q || out_ready_i) begin
               out_valid_d = 1'b1;
               out_page_d  = xf_page_out;
               out_idx_d   = '0;
`ifdef KECCAK_THETA_PARITY_OUT_EN
               out_par_d   = p0_par_q;
`endif
               state_d     = DRAIN;
            end
         end
         DRAIN: begin
            if (out_valid_q && out_ready_i) begin
               state_d = FIRST;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = FIRST;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FIRST;
         cnt_q       <= '0;
         p0_page_q   <= '0;
         p0_par_q    <= '0;
         prev_par_q  <= '0;
         out_valid_q <= 1'b0;
         out_page_q  <= '0;
         out_idx_q   <= '0;
`ifdef KECCAK_THETA_PARITY_OUT_EN
         out_par_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         p0_page_q   <= p0_page_d;
         p0_par_q    <= p0_par_d;
         prev_par_q  <= prev_par_d;
         out_valid_q <= out_valid_d;
         out_page_q  <= out_page_d;
         out_idx_q   <= out_idx_d;
`ifdef KECCAK_THETA_PARITY_OUT_EN
         out_par_q   <= out_par_d;
`endif
      end
   end

   assign in_ready_o  = in_ready_c;
   assign out_valid_o = out_valid_q;
   assign out_page_o  = out_page_q;
   assign out_idx_o   = out_idx_q;
`ifdef KECCAK_THETA_PARITY_OUT_EN
   assign out_parity_o = out_par_q;
`endif

endmodule

// File: tb/tb_keccak_theta_stream.sv
// Self-checking bench for keccak_theta_stream with LANE_W=4.
// Directed table vectors, stall and mid-state reset sequences, then
// randomized states checked against a column-parity reference model.
module tb_keccak_theta_stream;

   localparam int LW = 4;

   typedef struct {
      logic [LW-1:0][24:0] pg;
      logic [LW-1:0][24:0] ex;
   } vec_t;

   typedef struct {
      logic [1:0]  idx;
      logic [24:0] page;
      logic [4:0]  par;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] in_page;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] out_page;
   logic [1:0]  out_idx;
`ifdef KECCAK_THETA_PARITY_OUT_EN
   logic [4:0]  out_parity;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b1;
   bit   rand_rdy = 1'b0;
   exp_t exp_q[$];
   vec_t tbl[4];

   keccak_theta_stream #(.LANE_W(LW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_page_i   (in_page),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_page_o  (out_page),
      .out_idx_o   (out_idx)
`ifdef KECCAK_THETA_PARITY_OUT_EN
      ,
      .out_parity_o(out_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Column parity from plain column sums
   function automatic logic [4:0] colsum(input logic [24:0] p);
      logic [4:0]  c;
      logic [24:0] t;
      c = '0;
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            t = p >> (x + 5 * y);
            c = c ^ (5'(t[0]) << x);
         end
      end
      return c;
   endfunction

   // A'[x,y,z] = A[x,y,z] ^ C[x-1,z] ^ C[x+1,z-1]
   function automatic logic [LW-1:0][24:0] model(input logic [LW-1:0][24:0] a);
      logic [LW-1:0][24:0] e;
      logic [4:0] cz, cp;
      logic       b;
      for (int z = 0; z < LW; z++) begin
         cz = colsum(a[z]);
         cp = colsum(a[(z + LW - 1) % LW]);
         e[z] = a[z];
         for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
               b = 1'(cz >> ((x + 4) % 5)) ^ 1'(cp >> ((x + 1) % 5));
               e[z] = e[z] ^ (25'(b) << (x + 5 * y));
            end
         end
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Output scoreboard: compare every output handshake in order
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (mon_en && rst_n && out_valid && out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: idx %0d page %0h with none pending", out_idx, out_page);
         end else begin
            e = exp_q.pop_front();
            if (out_idx !== e.idx || out_page !== e.page) begin
               n_err++;
               $display("FAIL output: got idx %0d page %0h, expected idx %0d page %0h",
                        out_idx, out_page, e.idx, e.page);
            end
`ifdef KECCAK_THETA_PARITY_OUT_EN
            chk("out_parity", 32'(out_parity), 32'(e.par));
`endif
         end
      end
   end

   // Random backpressure
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_page(input logic [24:0] p);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_page  = p;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         n_err++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d outputs missing, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic push_exp(input logic [LW-1:0][24:0] pg, input logic [LW-1:0][24:0] ex);
      exp_t e;
      for (int k = 1; k <= LW; k++) begin
         e.idx  = 2'(k % LW);
         e.page = ex[k % LW];
         e.par  = colsum(pg[k % LW]);
         exp_q.push_back(e);
      end
   endtask

   task automatic run_state(input logic [LW-1:0][24:0] pg, input logic [LW-1:0][24:0] ex,
                            input bit rnd);
      push_exp(pg, ex);
      for (int z = 0; z < LW; z++) begin
         if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         send_page(pg[z]);
      end
      @(negedge clk);
      chk("in_ready_flush", 32'(in_ready), 32'd0);
      wait_drain();
   endtask

   initial begin
      logic [LW-1:0][24:0] rp;

      tbl[0].pg = '0;  tbl[0].ex = '0;
      tbl[1].pg = '0;  tbl[1].ex = '0;
      tbl[1].pg[1] = 25'h1;
      tbl[1].ex[1] = 25'h0210843;
      tbl[1].ex[2] = 25'h1084210;
      tbl[2].pg = '0;  tbl[2].ex = '0;
      tbl[2].pg[3] = 25'h1;
      tbl[2].ex[3] = 25'h0210843;
      tbl[2].ex[0] = 25'h1084210;
      tbl[3].pg = '0;  tbl[3].ex = '0;
      tbl[3].pg[0] = 25'h1;
      tbl[3].ex[0] = 25'h0210843;
      tbl[3].ex[1] = 25'h1084210;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_page   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_page",  32'(out_page),  32'd0);
      chk("rst_out_idx",   32'(out_idx),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 4; i++) begin
         run_state(tbl[i].pg, tbl[i].ex, 1'b0);
      end

      // Output stall after the idx1 result
      out_ready = 1'b0;
      push_exp(tbl[1].pg, tbl[1].ex);
      send_page(tbl[1].pg[0]);
      send_page(tbl[1].pg[1]);
      in_valid = 1'b1;
      in_page  = tbl[1].pg[2];
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_out_idx",   32'(out_idx),   32'd1);
         chk("stall_out_page",  32'(out_page),  32'h0210843);
         chk("stall_in_ready",  32'(in_ready),  32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_page(tbl[1].pg[2]);
      send_page(tbl[1].pg[3]);
      wait_drain();

      // Reset after page 2 is accepted
      mon_en = 1'b0;
      send_page('0);
      send_page('0);
      send_page('0);
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_idx",   32'(out_idx),   32'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      exp_q.delete();
      run_state(tbl[0].pg, tbl[0].ex, 1'b0);
      run_state(tbl[2].pg, tbl[2].ex, 1'b0);

      // Random states with random gaps and backpressure
      rand_rdy = 1'b1;
      for (int s = 0; s < 24; s++) begin
         for (int z = 0; z < LW; z++) rp[z] = 25'($urandom);
         run_state(rp, model(rp), 1'b1);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
